data_cache_wb: RTL
==================

// Module: data_cache_wb
// PURPOSE
//  Parametrised direct-mapped, write-back, write-allocate data cache between the core LSU and data_memory.
//  Single request port with valid/ready handshake; misses stall the requester, never return stale data.
//  Block-granular memory port with req/ack handshake.
//  Dirty victims are written back before the refill is issued.
// PARAMETERS
//  WORD_SIZE    32  bits per word
//  BLOCK_WORDS  16  words per line (power of 2, >=2); OFF_BITS=clog2(BLOCK_WORDS)
//  INDEX_BITS   10  line index bits; LINES=2**INDEX_BITS
//  ADDR_WIDTH   32  word-address width; TAG_BITS=ADDR_WIDTH-INDEX_BITS-OFF_BITS
// PORTS
//  clk         in   1                     clock, all state on posedge
//  rst_n       in   1                     async active-low reset
//  req_valid   in   1                     request present
//  req_ready   out  1                     cache can accept request this cycle
//  req_write   in   1                     1=store, 0=load
//  req_addr    in   ADDR_WIDTH            word address {tag,index,offset}
//  req_wdata   in   WORD_SIZE             store data
//  resp_valid  out  1                     one-cycle pulse, response for oldest accepted request
//  resp_rdata  out  WORD_SIZE             load data (0 for stores)
//  resp_hit    out  1                     1 if request hit without memory traffic
//  mem_req     out  1                     memory transaction request
//  mem_we      out  1                     1=writeback, 0=refill
//  mem_addr    out  ADDR_WIDTH            block base address (offset bits 0)
//  mem_wblock  out  WORD_SIZE*BLOCK_WORDS victim line
//  mem_ack     in   1                     one-cycle completion; mem_rblock valid same cycle
//  mem_rblock  in   WORD_SIZE*BLOCK_WORDS refill line
// BEHAVIOUR
//  Reset (async, rst_n=0): all valid/dirty bits 0, FSM=IDLE, req_ready=1 after release.
//   resp_valid=0, resp_rdata=0, resp_hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wblock=0.
//   Reset mid-miss abandons the transaction: mem_req drops asynchronously; dirty data is lost.
//  Line layout: word k at bits [k*WORD_SIZE +: WORD_SIZE].
//  FSM states: IDLE, WB, REFILL, RESP.
//   IDLE: req_ready=1. Accept when req_valid&&req_ready; latch addr/wdata/write.
//    Hit: resp next cycle (latency 1), stay IDLE; back-to-back hits accepted every cycle.
//    Miss, victim valid&&dirty -> WB. Otherwise -> REFILL. req_ready=0 outside IDLE.
//   WB: mem_req=1, mem_we=1, mem_addr={victim_tag,index,0}, mem_wblock=line.
//    Outputs held stable until mem_ack. On mem_ack -> REFILL.
//   REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,0}.
//    On mem_ack: line<=mem_rblock, tag set, valid=1, dirty=0 -> RESP.
//   RESP: serve latched request against the now-resident line with resp_hit=0; -> IDLE.
//  Store hit/after refill: merge word at offset, dirty=1; other words unchanged.
//  Load: resp_rdata=word at offset; loads never set dirty.
//  mem_req deasserts the cycle after mem_ack. WB->REFILL has one idle mem_req cycle.
//  mem_ack while mem_req=0 is ignored.
//  Tag compare uses state before the accepting edge. A hit to a line written by the
//   previous request returns updated data (no read-during-write hazard).
// CONFIGURATION
//  DATA_CACHE_WB_STATS_EN defined: adds outputs stat_hits, stat_misses, stat_wbacks (32 b each).
//   Counters increment per accepted-hit / miss / writeback; saturate at all-ones; reset to 0.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package dcache_pkg: state enum (IDLE,WB,REFILL,RESP), field-width functions (OFF/INDEX/TAG),
//   address split helpers.
//  Sub-module dcache_line_store: tag/valid/dirty/data arrays.
//   Provides 1 read + 1 write port, async-reset valid/dirty; FSM stays in data_cache_wb.
// TESTING
//  1 Cold load 0x0000_0040 (mem line word0=0xDEAD_BEEF) -> REFILL, no WB, resp_hit=0, rdata=0xDEADBEEF.
//  2 Store 0x41=0x1234_5678 then load 0x41 -> hits, resp at +1 cycle, rdata=0x12345678, dirty=1.
//  3 Load 0x0004_0040 (same index, new tag) -> WB mem_addr=0x40 with word1=0x12345678, then REFILL 0x40040.
//  4 Back-to-back hits 0x40040..0x4004F, req_valid held -> 16 responses in 16 consecutive cycles.
//  5 mem_ack delayed 7 cycles -> mem_req/addr/wblock stable throughout, req_ready=0 until RESP done.
//  6 rst_n low during REFILL -> mem_req=0 immediately; after release load 0x40040 misses (valid cleared).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and field helpers for the write-back data cache.
// Optional statistics counters are enabled with DATA_CACHE_WB_STATS_EN.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        RESP
    } state_t;

    function automatic int off_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int index_bits(input int ib);
        return ib;
    endfunction

    function automatic int tag_bits(input int aw, input int ib, input int bw);
        return aw - ib - $clog2(bw);
    endfunction

    // Extract a w-bit field starting at lsb from a word address.
    function automatic logic [63:0] addr_field(
        input logic [63:0] a,
        input int          lsb,
        input int          w
    );
        return (a >> lsb) & ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag, valid, dirty and data arrays of the direct-mapped cache.
// One asynchronous read port and one full-line write port.
module dcache_line_store #(
    parameter int LINE_BITS  = 512,
    parameter int INDEX_BITS = 10,
    parameter int TAG_BITS   = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [LINE_BITS-1:0]  wr_line,
    input  logic                  wr_dirty
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    // Any written line becomes valid; only the flags need reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache between LSU and memory.
// Define DATA_CACHE_WB_STATS_EN to add hit/miss/writeback counters.
module data_cache_wb
    import dcache_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int INDEX_BITS  = 10,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [WORD_SIZE-1:0]             req_wdata,
    output logic                             resp_valid,
    output logic [WORD_SIZE-1:0]             resp_rdata,
    output logic                             resp_hit,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_wblock,
    input  logic                             mem_ack,
    input  logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_rblock
`ifdef DATA_CACHE_WB_STATS_EN
    ,
    output logic [31:0]                      stat_hits,
    output logic [31:0]                      stat_misses,
    output logic [31:0]                      stat_wbacks
`endif
);

    localparam int OFF_BITS  = off_bits(BLOCK_WORDS);
    localparam int IDX_BITS  = index_bits(INDEX_BITS);
    localparam int TAG_BITS  = tag_bits(ADDR_WIDTH, INDEX_BITS, BLOCK_WORDS);
    localparam int LINE_BITS = WORD_SIZE * BLOCK_WORDS;

    state_t                state;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [WORD_SIZE-1:0]  lat_wdata;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [WORD_SIZE-1:0]  cur_wdata;
    logic [OFF_BITS-1:0]   cur_off;
    logic [IDX_BITS-1:0]   cur_idx;
    logic [TAG_BITS-1:0]   cur_tag;

    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic [WORD_SIZE-1:0]  rd_word;
    logic [LINE_BITS-1:0]  merged;
    logic                  hit;

    logic                  wr_en;
    logic [LINE_BITS-1:0]  wr_line;
    logic                  wr_dirty;

    // In IDLE the array is looked up with the live request, else the latched one.
    assign cur_addr  = (state == IDLE) ? req_addr : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_off   = OFF_BITS'(addr_field(64'(cur_addr), 0, OFF_BITS));
    assign cur_idx   = IDX_BITS'(addr_field(64'(cur_addr), OFF_BITS, IDX_BITS));
    assign cur_tag   = TAG_BITS'(addr_field(64'(cur_addr), OFF_BITS + IDX_BITS, TAG_BITS));

    assign hit       = rd_valid && (rd_tag == cur_tag);
    assign req_ready = (state == IDLE);

    dcache_line_store #(
        .LINE_BITS  (LINE_BITS),
        .INDEX_BITS (IDX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (cur_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_idx   (cur_idx),
        .wr_tag   (cur_tag),
        .wr_line  (wr_line),
        .wr_dirty (wr_dirty)
    );

    always_comb begin
        rd_word = '0;
        merged  = rd_line;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            if (cur_off == OFF_BITS'(k)) begin
                rd_word = rd_line[k*WORD_SIZE +: WORD_SIZE];
                merged[k*WORD_SIZE +: WORD_SIZE] = cur_wdata;
            end
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_line  = merged;
        wr_dirty = 1'b1;
        unique case (state)
            IDLE:    wr_en = req_valid && hit && req_write;
            REFILL: begin
                wr_en    = mem_req && mem_ack;
                wr_line  = mem_rblock;
                wr_dirty = 1'b0;
            end
            RESP:    wr_en = lat_write;
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_hit   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wblock <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        if (hit) begin
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b1;
                            resp_rdata <= req_write ? '0 : rd_word;
                        end else if (rd_valid && rd_dirty) begin
                            state      <= WB;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b1;
                            mem_addr   <= {rd_tag, cur_idx, {OFF_BITS{1'b0}}};
                            mem_wblock <= rd_line;
                        end else begin
                            state    <= REFILL;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {cur_tag, cur_idx, {OFF_BITS{1'b0}}};
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= REFILL;
                    end
                end
                REFILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cur_tag, cur_idx, {OFF_BITS{1'b0}}};
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    resp_rdata <= lat_write ? '0 : rd_word;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_CACHE_WB_STATS_EN
    logic evt_hit;
    logic evt_miss;
    logic evt_wb;

    assign evt_hit  = (state == IDLE) && req_valid && hit;
    assign evt_miss = (state == IDLE) && req_valid && !hit;
    assign evt_wb   = (state == WB) && mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbacks <= '0;
        end else begin
            if (evt_hit && stat_hits != '1)
                stat_hits <= stat_hits + 32'd1;
            if (evt_miss && stat_misses != '1)
                stat_misses <= stat_misses + 32'd1;
            if (evt_wb && stat_wbacks != '1)
                stat_wbacks <= stat_wbacks + 32'd1;
        end
    end
`endif

endmodule
